// File: rtl/fpga_cfg_pkg.sv
// Shared constants and types for the tile configuration path.
// Used by the loader and by the tile wrapper around it.
package fpga_cfg_pkg;

  localparam int LUT_BITS = 32;
  localparam int SB_BITS = 16;
  localparam int PAYLOAD_BITS = LUT_BITS + 1 + SB_BITS;
  localparam int CNT_W = 6;

  localparam logic [7:0] SYNC_WORD = 8'hA5;

  localparam int LUT_LSB = 0;
  localparam int FF_BIT = 32;
  localparam int SB_LSB = 33;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    PARITY
  } state_e;

endpackage

// File: rtl/tile_config_loader.sv
// Serial config loader: sync hunt, 49-bit payload, even parity,
// atomic commit of LUT, register select and switch-box config.
module tile_config_loader
  import fpga_cfg_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                din_valid,
  input  logic                din,
  output logic [LUT_BITS-1:0] lut_mem,
  output logic                lut_ff_sel,
  output logic [SB_BITS-1:0]  sb_configure,
  output logic                cfg_loaded,
  output logic                cfg_done,
  output logic                cfg_error,
  output logic                busy
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(PAYLOAD_BITS - 1);

  state_e                  state_q, state_d;
  logic [7:0]              sync_q, sync_d;
  logic [7:0]              sync_nxt;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    par_q, par_d;
  logic [PAYLOAD_BITS-1:0] shd_q, shd_d;
  logic [LUT_BITS-1:0]     lut_q, lut_d;
  logic                    ff_q, ff_d;
  logic [SB_BITS-1:0]      sb_q, sb_d;
  logic                    ld_q, ld_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  assign sync_nxt = {sync_q[6:0], din};

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    shd_d   = shd_q;
    lut_d   = lut_q;
    ff_d    = ff_q;
    sb_d    = sb_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          sync_d = sync_nxt;
          if (sync_nxt == SYNC_WORD) begin
            state_d = PAYLOAD;
            cnt_d   = '0;
            par_d   = 1'b0;
          end
        end
        PAYLOAD: begin
          shd_d[cnt_q] = din;
          par_d = par_q ^ din;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = PARITY;
        end
        PARITY: begin
          if ((par_q ^ din) == 1'b0) begin
            lut_d  = shd_q[LUT_LSB +: LUT_BITS];
            ff_d   = shd_q[FF_BIT];
            sb_d   = shd_q[SB_LSB +: SB_BITS];
            ld_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = HUNT;
          sync_d  = '0;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HUNT;
      sync_q  <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      shd_q   <= '0;
      lut_q   <= '0;
      ff_q    <= 1'b0;
      sb_q    <= '0;
      ld_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      shd_q   <= shd_d;
      lut_q   <= lut_d;
      ff_q    <= ff_d;
      sb_q    <= sb_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign lut_mem      = lut_q;
  assign lut_ff_sel   = ff_q;
  assign sb_configure = sb_q;
  assign cfg_loaded   = ld_q;
  assign cfg_done     = done_q;
  assign cfg_error    = err_q;
  assign busy = (state_q == PAYLOAD) ||
                (state_q == PARITY);

endmodule
